// File: rtl/memif_apb_master_if.sv
// rtl/memif_apb_master_if.sv - memory-request and APB signal bundle for memif_apb_master
//
// Purpose: carries the memory-side request/completion handshake and the APB
// master bus as one bundle.
// Ports (signals):
//   mreq_i, maddr_i, mwe_i, mwdata_i, mstrb_i   memory request (into the master)
//   mack_o, mrdata_o, mresp_o, busy_o           memory completion/status (out of the master)
//   psel_o, penable_o, paddr_o, pwrite_o,
//   pwdata_o, pstrb_o                           APB request (out of the master)
//   pready_i, prdata_i, pslverr_i               APB response (into the master)
// Modports: master (the bridge), slave (the request source and APB completer side).

interface memif_apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  mreq_i;
    logic [ADDR_WIDTH-1:0] maddr_i;
    logic                  mwe_i;
    logic [DATA_WIDTH-1:0] mwdata_i;
    logic [STRB_WIDTH-1:0] mstrb_i;
    logic                  mack_o;
    logic [DATA_WIDTH-1:0] mrdata_o;
    logic                  mresp_o;
    logic                  busy_o;

    logic                  psel_o;
    logic                  penable_o;
    logic [ADDR_WIDTH-1:0] paddr_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport master (
        input  mreq_i, maddr_i, mwe_i, mwdata_i, mstrb_i,
        input  pready_i, prdata_i, pslverr_i,
        output mack_o, mrdata_o, mresp_o, busy_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output mreq_i, maddr_i, mwe_i, mwdata_i, mstrb_i,
        output pready_i, prdata_i, pslverr_i,
        input  mack_o, mrdata_o, mresp_o, busy_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/memif_apb_master.sv
// rtl/memif_apb_master.sv - bridges single-cycle memory requests onto an APB master bus
//
// Purpose: accepts a one-cycle memory request, runs it as one APB transfer
// (IDLE -> SETUP -> ACCESS -> IDLE) and reports completion with a one-cycle
// mack_o pulse carrying read data and the error flag.
// Ports:
//   clk_i     single clock, rising edge
//   arst_ni   asynchronous active-low reset
//   bus       memif_apb_master_if.master: memory request/completion and APB bus
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES (ACCESS-phase timeout limit).
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase that
// sees pready_i low for TIMEOUT_CYCLES consecutive cycles (completes with mresp_o=1).

module memif_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    memif_apb_master_if.master  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic accept;     // request taken in IDLE this cycle
    logic complete;   // ACCESS finishes with pready_i this cycle
    logic timeout;    // ACCESS abandoned by the timeout this cycle
    logic expired;    // timeout limit reached in the current ACCESS cycle

    logic                  psel_q;
    logic                  penable_q;
    logic                  busy_q;
    logic                  mack_q;
    logic                  mresp_q;
    logic [DATA_WIDTH-1:0] mrdata_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Counts ACCESS cycles that ended with pready_i low. The limit is hit in
    // the cycle where TIMEOUT_CYCLES-1 earlier cycles have already stalled, so
    // a pready_i in that same cycle still wins over the timeout.
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !bus.pready_i) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout, ACCESS waits for pready_i for as long as it takes.
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Requests arriving while busy never reach this branch, so
                // they are dropped without latching anything.
                if (bus.mreq_i) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready_i) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else if (expired) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // APB control and status are registered from the next state so that the
    // outputs line up with the state the FSM is actually in.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            mack_q    <= 1'b0;
        end else begin
            psel_q    <= (state_d != ST_IDLE);
            penable_q <= (state_d == ST_ACCESS);
            busy_q    <= (state_d != ST_IDLE);
            mack_q    <= complete | timeout;
        end
    end

    // Request fields are captured once at acceptance and held through the
    // whole transfer; response fields change only on a completion.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            mrdata_q <= '0;
            mresp_q  <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.maddr_i;
                pwrite_q <= bus.mwe_i;
                pwdata_q <= bus.mwdata_i;
                pstrb_q  <= bus.mstrb_i;
            end
            if (complete) begin
                mresp_q <= bus.pslverr_i;
                if (!pwrite_q) begin
                    mrdata_q <= bus.prdata_i;
                end
            end else if (timeout) begin
                mresp_q <= 1'b1;
            end
        end
    end

    assign bus.psel_o    = psel_q;
    assign bus.penable_o = penable_q;
    assign bus.paddr_o   = paddr_q;
    assign bus.pwrite_o  = pwrite_q;
    assign bus.pwdata_o  = pwdata_q;
    assign bus.pstrb_o   = pstrb_q;
    assign bus.busy_o    = busy_q;
    assign bus.mack_o    = mack_q;
    assign bus.mrdata_o  = mrdata_q;
    assign bus.mresp_o   = mresp_q;

endmodule

// File: tb/tb_memif_apb_master.sv
// tb/tb_memif_apb_master.sv - self-checking bench for memif_apb_master

module tb_memif_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int MAX_WAIT = TO - 1;
`else
    localparam int MAX_WAIT = 8;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    memif_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memif_apb_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .arst_ni(arst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the requester should currently see on the response side.
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_resp  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd,
                         input logic [3:0] st);
        bus.mreq_i   = 1'b1;
        bus.maddr_i  = a;
        bus.mwe_i    = we;
        bus.mwdata_i = wd;
        bus.mstrb_i  = st;
    endtask

    task automatic poke_if(input bit poke);
        bus.mreq_i = poke;
        if (poke) begin
            bus.maddr_i  = $urandom;
            bus.mwe_i    = 1'($urandom_range(0, 1));
            bus.mwdata_i = $urandom;
            bus.mstrb_i  = 4'($urandom);
        end
    endtask

    task automatic chk_req(input string ph, input logic [AW-1:0] a, input bit we,
                           input logic [DW-1:0] wd, input logic [3:0] st, input bit pen);
        chk({ph, "_psel"}, 64'(bus.psel_o), 64'(1));
        chk({ph, "_penable"}, 64'(bus.penable_o), 64'(pen));
        chk({ph, "_busy"}, 64'(bus.busy_o), 64'(1));
        chk({ph, "_mack"}, 64'(bus.mack_o), 64'(0));
        chk({ph, "_paddr"}, 64'(bus.paddr_o), 64'(a));
        chk({ph, "_pwrite"}, 64'(bus.pwrite_o), 64'(we));
        chk({ph, "_pwdata"}, 64'(bus.pwdata_o), 64'(wd));
        chk({ph, "_pstrb"}, 64'(bus.pstrb_o), 64'(st));
        chk({ph, "_mrdata_hold"}, 64'(bus.mrdata_o), 64'(exp_rdata));
        chk({ph, "_mresp_hold"}, 64'(bus.mresp_o), 64'(exp_resp));
    endtask

    // Entered at the negedge where the request is already driven; returns at
    // the negedge of the mack_o cycle with mreq_i released.
    task automatic body(input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd,
                        input logic [3:0] st, input int waits, input bit to,
                        input bit err, input logic [DW-1:0] rd, input bit poke);
        int n_acc;
        bit last;
        n_acc = to ? TO : waits + 1;
        @(negedge clk);
        chk_req("setup", a, we, wd, st, 1'b0);
        poke_if(poke);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            chk_req("access", a, we, wd, st, 1'b1);
            last = !to && (i == n_acc - 1);
            bus.pready_i  = last;
            bus.prdata_i  = last ? rd : DW'($urandom);
            bus.pslverr_i = last ? err : 1'($urandom_range(0, 1));
            poke_if(poke);
        end
        @(negedge clk);
        bus.mreq_i   = 1'b0;
        bus.pready_i = 1'b0;
        if (to) begin
            exp_resp = 1'b1;
        end else begin
            exp_resp = err;
            if (!we) exp_rdata = rd;
        end
        chk("done_mack", 64'(bus.mack_o), 64'(1));
        chk("done_mresp", 64'(bus.mresp_o), 64'(exp_resp));
        chk("done_mrdata", 64'(bus.mrdata_o), 64'(exp_rdata));
        chk("done_busy", 64'(bus.busy_o), 64'(0));
        chk("done_psel", 64'(bus.psel_o), 64'(0));
        chk("done_penable", 64'(bus.penable_o), 64'(0));
    endtask

    task automatic idle_after;
        @(negedge clk);
        chk("after_mack", 64'(bus.mack_o), 64'(0));
        chk("after_busy", 64'(bus.busy_o), 64'(0));
        chk("after_psel", 64'(bus.psel_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic [3:0]    st;
        bit            we;
        bit            err;
        bit            b2b;
        int            waits;

        bus.mreq_i = 1'b0; bus.maddr_i = '0; bus.mwe_i = 1'b0; bus.mwdata_i = '0;
        bus.mstrb_i = '0; bus.pready_i = 1'b0; bus.prdata_i = '0; bus.pslverr_i = 1'b0;

        // Reset state
        #3;
        chk("rst_psel", 64'(bus.psel_o), 64'(0));
        chk("rst_penable", 64'(bus.penable_o), 64'(0));
        chk("rst_mack", 64'(bus.mack_o), 64'(0));
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_mresp", 64'(bus.mresp_o), 64'(0));
        chk("rst_mrdata", 64'(bus.mrdata_o), 64'(0));
        chk("rst_paddr", 64'(bus.paddr_o), 64'(0));
        chk("rst_pwrite", 64'(bus.pwrite_o), 64'(0));
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Read, zero wait states
        issue(32'h10, 1'b0, 32'h0, 4'h0);
        body(32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
        idle_after();

        // Write, three wait states: read data must not move
        issue(32'h44, 1'b1, 32'hA5A5_0001, 4'h3);
        body(32'h44, 1'b1, 32'hA5A5_0001, 4'h3, 3, 1'b0, 1'b0, 32'h0BAD_0BAD, 1'b0);
        idle_after();

        // Error read followed by a clean write
        issue(32'h80, 1'b0, 32'h0, 4'h0);
        body(32'h80, 1'b0, 32'h0, 4'h0, 1, 1'b0, 1'b1, 32'h1357_9BDF, 1'b0);
        issue(32'h84, 1'b1, 32'h1111_2222, 4'hF);
        body(32'h84, 1'b1, 32'h1111_2222, 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_after();

        // Back-to-back issue in the mack cycle, with requests poked while busy
        issue(32'h100, 1'b0, 32'h0, 4'h0);
        body(32'h100, 1'b0, 32'h0, 4'h0, 2, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1);
        issue(32'h104, 1'b1, 32'h7777_8888, 4'hC);
        body(32'h104, 1'b1, 32'h7777_8888, 4'hC, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_after();

`ifndef APB_MASTER_TIMEOUT_EN
        // Without a timeout, a long stall still completes normally
        issue(32'h200, 1'b0, 32'h0, 4'h0);
        body(32'h200, 1'b0, 32'h0, 4'h0, 20, 1'b0, 1'b0, 32'h2468_ACE0, 1'b0);
        idle_after();
`endif

        // Randomized transfers
        b2b = 1'b0;
        for (int n = 0; n < 12; n++) begin
            a     = $urandom;
            we    = 1'($urandom_range(0, 1));
            wd    = $urandom;
            rd    = $urandom;
            st    = 4'($urandom);
            err   = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, MAX_WAIT);
            issue(a, we, wd, st);
            body(a, we, wd, st, waits, 1'b0, err, rd, 1'($urandom_range(0, 1)));
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) idle_after();
        end
        if (b2b) idle_after();

        // Reset in the middle of ACCESS
        issue(32'h300, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        bus.mreq_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_penable", 64'(bus.penable_o), 64'(1));
        #2 arst_n = 1'b0;
        #1;
        exp_rdata = '0;
        exp_resp  = 1'b0;
        chk("mid_rst_psel", 64'(bus.psel_o), 64'(0));
        chk("mid_rst_penable", 64'(bus.penable_o), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy_o), 64'(0));
        chk("mid_rst_mrdata", 64'(bus.mrdata_o), 64'(0));
        chk("mid_rst_paddr", 64'(bus.paddr_o), 64'(0));
        chk("mid_rst_pwdata", 64'(bus.pwdata_o), 64'(0));
        chk("mid_rst_pstrb", 64'(bus.pstrb_o), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_rst_mack", 64'(bus.mack_o), 64'(0));
        end
        bus.pready_i = 1'b1;
        arst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_mack", 64'(bus.mack_o), 64'(0));
            chk("post_rst_busy", 64'(bus.busy_o), 64'(0));
        end
        bus.pready_i = 1'b0;
        issue(32'h10, 1'b0, 32'h0, 4'h0);
        body(32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h5A5A_A5A5, 1'b0);
        idle_after();

`ifdef APB_MASTER_TIMEOUT_EN
        // Stall for the full limit: abort with error, read data unchanged
        issue(32'h400, 1'b0, 32'h0, 4'h0);
        body(32'h400, 1'b0, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle_after();
        // pready_i in the last allowed ACCESS cycle completes normally
        issue(32'h404, 1'b0, 32'h0, 4'h0);
        body(32'h404, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 1'b0, 32'hFACE_B00C, 1'b0);
        idle_after();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/memif_apb_master.md
MEMIF_APB_MASTER -- requirements
Module: memif_apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address width on both sides.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width; strobe width is DATA_WIDTH/8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the ACCESS-phase cycles allowed before abort (used only with REQ-026).
REQ-004 The block SHALL have these ports:
  clk_i  in  1  single clock, rising edge
  arst_ni  in  1  reset, asynchronous assert, active-low
  mreq_i  in  1  memory request pulse, one cycle
  maddr_i  in  ADDR_WIDTH  request address
  mwe_i  in  1  1 = write, 0 = read
  mwdata_i  in  DATA_WIDTH  write data
  mstrb_i  in  DATA_WIDTH/8  write byte strobe
  mack_o  out  1  completion pulse, one cycle
  mrdata_o  out  DATA_WIDTH  read data
  mresp_o  out  1  error flag, valid with mack_o
  busy_o  out  1  transfer in flight
  psel_o  out  1  APB select
  penable_o  out  1  APB enable
  paddr_o  out  ADDR_WIDTH  APB address
  pwrite_o  out  1  APB write
  pwdata_o  out  DATA_WIDTH  APB write data
  pstrb_o  out  DATA_WIDTH/8  APB strobe
  pready_i  in  1  APB ready
  prdata_i  in  DATA_WIDTH  APB read data
  pslverr_i  in  1  APB slave error

Function
REQ-005 The FSM SHALL have three states: IDLE, SETUP, ACCESS.
REQ-006 In IDLE, mreq_i=1 at edge N SHALL latch maddr_i, mwe_i, mwdata_i and mstrb_i, and the FSM SHALL enter SETUP at edge N.
REQ-007 In SETUP: psel_o=1, penable_o=0; the next edge SHALL move the FSM to ACCESS unconditionally.
REQ-008 In ACCESS: psel_o=1, penable_o=1; the FSM SHALL stay in ACCESS while pready_i=0.
REQ-009 In ACCESS with pready_i=1 at an edge, the FSM SHALL return to IDLE, and mack_o SHALL be 1 for exactly the following cycle.
REQ-010 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL be driven from the latched request and SHALL stay stable from SETUP through the end of ACCESS.
REQ-011 On read completion, mrdata_o SHALL capture prdata_i; on write completion, mrdata_o SHALL hold its previous value.
REQ-012 On every completion, mresp_o SHALL capture pslverr_i and hold it until the next completion.
REQ-013 busy_o SHALL be 1 in SETUP and ACCESS, and 0 in IDLE.
REQ-014 mreq_i while busy_o=1 SHALL be ignored: no latch, no state change, no mack_o.
REQ-015 mreq_i in the same cycle that mack_o=1 SHALL be accepted, because the FSM is in IDLE; back-to-back transfers therefore take 3 cycles minimum.
REQ-016 Minimum latency from mreq_i to mack_o SHALL be 3 cycles, with pready_i=1 in the first ACCESS cycle.
REQ-017 psel_o and penable_o SHALL be 0 in IDLE, and all APB outputs SHALL be registered.
REQ-018 pslverr_i and prdata_i SHALL be sampled only in an ACCESS cycle with pready_i=1.

Reset
REQ-019 Assertion of arst_ni=0 SHALL immediately force the FSM to IDLE.
REQ-020 During reset, psel_o, penable_o, mack_o, mresp_o and busy_o SHALL be 0.
REQ-021 During reset, mrdata_o, paddr_o, pwdata_o and pstrb_o SHALL be 0, and pwrite_o SHALL be 0.
REQ-022 Reset during SETUP or ACCESS SHALL abandon the transfer with no mack_o, either during or after reset.
REQ-023 The first request after deassertion SHALL be accepted normally.

Configuration
REQ-024 Macro APB_MASTER_TIMEOUT_EN SHALL enable the ACCESS timeout.
REQ-025 Without APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely for pready_i, and TIMEOUT_CYCLES SHALL be unused.
REQ-026 With APB_MASTER_TIMEOUT_EN, if pready_i=0 for TIMEOUT_CYCLES consecutive ACCESS cycles, the FSM SHALL go to IDLE and assert mack_o=1 with mresp_o=1 for one cycle, leaving mrdata_o unchanged.
REQ-027 With APB_MASTER_TIMEOUT_EN, the counter SHALL clear on entry to ACCESS, and pready_i=1 in the final allowed cycle SHALL complete normally rather than time out.

Verification
REQ-028 Read, 0 wait states: mreq_i, maddr_i=0x10, mwe_i=0, prdata_i=0xDEADBEEF -> SETUP at +1, ACCESS at +2, mack_o at +3, mrdata_o=0xDEADBEEF, mresp_o=0.
REQ-029 Write with 3 wait states: mwdata_i=0xA5A5_0001, mstrb_i=0x3 -> pwdata_o and pstrb_o stable over 4 ACCESS cycles, mack_o at +6, mrdata_o unchanged.
REQ-030 Error response: read with pslverr_i=1 at pready_i -> mack_o=1, mresp_o=1; a following clean write gives mresp_o=0.
REQ-031 Back-to-back and busy: mreq_i in the mack_o cycle is accepted; mreq_i during ACCESS is ignored, with exactly one mack_o.
REQ-032 Reset: arst_ni low mid-ACCESS -> psel_o and penable_o go 0 immediately, no mack_o, and the next read completes normally.
REQ-033 Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready_i held 0 -> mack_o=1, mresp_o=1 after 4 ACCESS cycles; pready_i=1 in the 4th ACCESS cycle -> normal completion.
